// File: rtl/integration_mem_copy_master.sv
// Avalon-MM copy master: reads one word, waits out the slave's fixed read
// latency, writes that word to the destination, then moves to the next word.
module integration_mem_copy_master #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    length,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [2:0]        lat_q, lat_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              rd_q, rd_d, wr_q, wr_d, cs_q, cs_d;
  logic              busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic computes the strobes for the following cycle so every
  // bus output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          rem_d = length;
          if (length == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            addr_d  = src_addr;
          end
        end
      end
      RD_REQ: begin
        if (avm_waitrequest) begin
          rd_d = 1'b1;
        end else begin
          lat_d   = 3'(READ_LATENCY);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          wdata_d = avm_readdata;
          wr_d    = 1'b1;
          addr_d  = dst_q;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (avm_waitrequest) begin
          wr_d = 1'b1;
        end else begin
          src_d = src_q + ADDR_W'(1);
          dst_d = dst_q + ADDR_W'(1);
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
            rd_d    = 1'b1;
            addr_d  = src_q + ADDR_W'(1);
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cs_d = rd_d | wr_d;
    be_d = {BE_W{cs_d}};
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_integration_mem_copy_master.sv
// Bench for the copy master: two instances (read latency 1 and 3), each with
// its own memory model and a scoreboard of expected read addresses and writes.
module tb_integration_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [12:0] src_addr = '0, dst_addr = '0, length = '0;

  logic        busy1, done1, cs1, rd1, wr1, wreq1;
  logic [3:0]  be1;
  logic [12:0] addr1;
  logic [31:0] wdata1, rdata1;
  logic        busy3, done3, cs3, rd3, wr3;
  logic        wreq3 = 1'b0;
  logic [3:0]  be3;
  logic [12:0] addr3;
  logic [31:0] wdata3, rdata3;

  logic        stall_en = 1'b0;
  logic [1:0]  stall_cnt = '0;
  logic        init_mem = 1'b0;
  logic [31:0] mem1 [8192];
  logic [31:0] mem3 [8192];
  logic [31:0] model1 [8192];
  logic [31:0] model3 [8192];
  logic [2:0]  rcnt1 = '0, rcnt3 = '0;
  logic [12:0] raddr1 = '0, raddr3 = '0;
  logic [12:0] rq1[$], rq3[$];
  logic [44:0] wq1[$], wq3[$];
  logic        prev_stall1 = 1'b0;
  logic [46:0] prev_vec1 = '0;
  int          n_tests = 0, n_fail = 0;
  int          strobes1 = 0;

  logic        sel = 1'b0;
  logic        s_busy, s_done, s_wr;
  logic [12:0] s_addr;
  logic [31:0] s_wdata;
  logic [53:0] s_outs;

  always #5 clk = ~clk;

  integration_mem_copy_master #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy1), .done(done1),
    .avm_address(addr1), .avm_byteenable(be1), .avm_chipselect(cs1),
    .avm_read(rd1), .avm_write(wr1), .avm_writedata(wdata1),
    .avm_readdata(rdata1), .avm_waitrequest(wreq1)
  );

  integration_mem_copy_master #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy3), .done(done3),
    .avm_address(addr3), .avm_byteenable(be3), .avm_chipselect(cs3),
    .avm_read(rd3), .avm_write(wr3), .avm_writedata(wdata3),
    .avm_readdata(rdata3), .avm_waitrequest(wreq3)
  );

  assign s_busy  = sel ? busy3 : busy1;
  assign s_done  = sel ? done3 : done1;
  assign s_wr    = sel ? wr3 : wr1;
  assign s_addr  = sel ? addr3 : addr1;
  assign s_wdata = sel ? wdata3 : wdata1;
  assign s_outs  = sel ? {busy3, done3, rd3, wr3, cs3, be3, addr3, wdata3}
                       : {busy1, done1, rd1, wr1, cs1, be1, addr1, wdata1};

  function automatic logic [31:0] pat(input int i);
    return (i >= 16 && i < 20) ? 32'(32'hA0 + i - 16) : (32'hC000_0000 | 32'(i));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Stall generator: every request sees waitrequest high for two cycles.
  assign wreq1 = stall_en && (rd1 || wr1) && (stall_cnt != 2'd2);
  always @(posedge clk) stall_cnt <= wreq1 ? stall_cnt + 2'd1 : 2'd0;

  // Memory models: readdata is valid only in the READ_LATENCY-th cycle.
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 8192; i++) mem1[13'(i)] <= pat(i);
    else if (wr1 && !wreq1) mem1[addr1] <= wdata1;
    if (rd1 && !wreq1) begin rcnt1 <= 3'd1; raddr1 <= addr1; end
    else if (rcnt1 != 3'd0) rcnt1 <= rcnt1 - 3'd1;
  end
  assign rdata1 = (rcnt1 == 3'd1) ? mem1[raddr1] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 8192; i++) mem3[13'(i)] <= pat(i);
    else if (wr3 && !wreq3) mem3[addr3] <= wdata3;
    if (rd3 && !wreq3) begin rcnt3 <= 3'd3; raddr3 <= addr3; end
    else if (rcnt3 != 3'd0) rcnt3 <= rcnt3 - 3'd1;
  end
  assign rdata3 = (rcnt3 == 3'd1) ? mem3[raddr3] : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (reset_n) begin
      check("cs_be_d1", 64'({cs1, be1}), (rd1 || wr1) ? 64'h1F : 64'h0);
      check("rd_wr_excl_d1", 64'(rd1 & wr1), 64'h0);
      if (prev_stall1) check("stall_hold_d1", 64'({rd1, wr1, addr1, wdata1}), 64'(prev_vec1));
      if (rd1 && !wreq1) begin
        if (rq1.size() == 0) check("rd_unexpected_d1", 64'h1, 64'h0);
        else check("rd_addr_d1", 64'(addr1), 64'(rq1.pop_front()));
      end
      if (wr1 && !wreq1) begin
        $display("[TB] dut1 write addr=%h data=%h", addr1, wdata1);
        if (wq1.size() == 0) check("wr_unexpected_d1", 64'h1, 64'h0);
        else check("wr_addr_data_d1", 64'({addr1, wdata1}), 64'(wq1.pop_front()));
      end
      if (rd1 || wr1) strobes1 <= strobes1 + 1;
    end
    prev_stall1 <= reset_n && (rd1 || wr1) && wreq1;
    prev_vec1   <= {rd1, wr1, addr1, wdata1};
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("cs_be_d3", 64'({cs3, be3}), (rd3 || wr3) ? 64'h1F : 64'h0);
      check("rd_wr_excl_d3", 64'(rd3 & wr3), 64'h0);
      if (rd3) begin
        if (rq3.size() == 0) check("rd_unexpected_d3", 64'h1, 64'h0);
        else check("rd_addr_d3", 64'(addr3), 64'(rq3.pop_front()));
      end
      if (wr3) begin
        $display("[TB] dut3 write addr=%h data=%h", addr3, wdata3);
        if (wq3.size() == 0) check("wr_unexpected_d3", 64'h1, 64'h0);
        else check("wr_addr_data_d3", 64'({addr3, wdata3}), 64'(wq3.pop_front()));
      end
    end
  end

  // Reference copy: strictly ascending read-then-write per word.
  task automatic plan(input bit which, input logic [12:0] s, input logic [12:0] d,
                      input logic [12:0] n);
    logic [12:0] ra, wa;
    logic [31:0] v;
    for (int i = 0; i < int'(n); i++) begin
      ra = s + 13'(i);
      wa = d + 13'(i);
      if (which) begin
        v = model3[ra]; model3[wa] = v; rq3.push_back(ra); wq3.push_back({wa, v});
      end else begin
        v = model1[ra]; model1[wa] = v; rq1.push_back(ra); wq1.push_back({wa, v});
      end
    end
  endtask

  task automatic mem_cmp(input bit which, input string tag);
    int errs = 0;
    for (int i = 0; i < 8192; i++) begin
      if (which ? (mem3[13'(i)] !== model3[13'(i)]) : (mem1[13'(i)] !== model1[13'(i)])) errs++;
    end
    check(tag, 64'(errs), 64'h0);
  endtask

  task automatic pulse_start(input bit which, input logic [12:0] s, input logic [12:0] d,
                             input logic [12:0] n);
    @(negedge clk);
    sel = which;
    src_addr = s; dst_addr = d; length = n;
    if (which) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic run_copy(input bit which, input logic [12:0] s, input logic [12:0] d,
                          input logic [12:0] n, input int exp_done, input int exp_busy,
                          input int glitch_at);
    int k, busy_n, done_at;
    logic busy_at_done;
    plan(which, s, d, n);
    pulse_start(which, s, d, n);
    k = 1; busy_n = 0; done_at = -1; busy_at_done = 1'b1;
    while (k <= 200) begin
      if (s_done) begin
        done_at = k; busy_at_done = s_busy;
        break;
      end
      if (s_busy) busy_n++;
      if (k == glitch_at) begin
        src_addr = 13'h050; dst_addr = 13'h300; length = 13'd2;
        if (which) start3 = 1'b1; else start1 = 1'b1;
      end
      @(posedge clk);
      #1;
      start1 = 1'b0; start3 = 1'b0;
      k++;
    end
    check("done_cycle", 64'(done_at), 64'(exp_done));
    check("busy_cycles", 64'(busy_n), 64'(exp_busy));
    check("busy_low_at_done", 64'(busy_at_done), 64'h0);
    @(posedge clk);
    #1;
    check("done_single_pulse", 64'(s_done), 64'h0);
    check("rd_queue_drained", 64'(which ? rq3.size() : rq1.size()), 64'h0);
    check("wr_queue_drained", 64'(which ? wq3.size() : wq1.size()), 64'h0);
    mem_cmp(which, "mem_image");
  endtask

  // Reset lands mid-cycle during the write request of word 2 of a 4-word copy.
  task automatic reset_mid(input bit which, input int lat);
    logic [12:0] d;
    logic [31:0] w2;
    int target;
    d = which ? 13'h600 : 13'h400;
    target = 3 * (2 + lat);
    plan(which, 13'h010, d, 13'd4);
    pulse_start(which, 13'h010, d, 13'd4);
    for (int k = 1; k < target; k++) begin
      @(posedge clk);
      #1;
    end
    check("word2_write_strobe", 64'(s_wr), 64'h1);
    check("word2_write_addr", 64'(s_addr), 64'(d + 13'd2));
    check("word2_write_data", 64'(s_wdata), 64'(pat(18)));
    reset_n = 1'b0;
    #1;
    check("outputs_in_reset", 64'(s_outs), 64'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_done_in_reset", 64'(s_done), 64'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("no_done_after_reset", 64'({s_busy, s_done}), 64'h0);
    rq1.delete(); wq1.delete(); rq3.delete(); wq3.delete();
    w2 = which ? mem3[d + 13'd2] : mem1[d + 13'd2];
    check("word2_old_or_new", 64'((w2 === pat(int'(d) + 2)) || (w2 === pat(18))), 64'h1);
    if (which) begin
      model3[d + 13'd2] = w2; model3[d + 13'd3] = pat(int'(d) + 3);
    end else begin
      model1[d + 13'd2] = w2; model1[d + 13'd3] = pat(int'(d) + 3);
    end
    mem_cmp(which, "mem_after_reset");
  endtask

  initial begin
    int st;
    for (int i = 0; i < 8192; i++) begin
      model1[13'(i)] = pat(i);
      model3[13'(i)] = pat(i);
    end
    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    sel = 1'b0;
    #1;
    check("reset_outputs_d1", 64'(s_outs), 64'h0);
    sel = 1'b1;
    #1;
    check("reset_outputs_d3", 64'(s_outs), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    run_copy(1'b0, 13'h010, 13'h100, 13'd4, 13, 12, 0);
    stall_en = 1'b1;
    run_copy(1'b0, 13'h010, 13'h100, 13'd4, 29, 28, 0);
    stall_en = 1'b0;
    st = strobes1;
    run_copy(1'b0, 13'h020, 13'h180, 13'd0, 1, 0, 0);
    check("len0_no_strobes", 64'(strobes1 - st), 64'h0);
    run_copy(1'b0, 13'h1FFE, 13'h0000, 13'd4, 13, 12, 0);
    run_copy(1'b0, 13'h010, 13'h200, 13'd4, 13, 12, 5);
    reset_mid(1'b0, 1);
    run_copy(1'b0, 13'h010, 13'h800, 13'd4, 13, 12, 0);

    run_copy(1'b1, 13'h010, 13'h100, 13'd4, 21, 20, 0);
    reset_mid(1'b1, 3);
    run_copy(1'b1, 13'h013, 13'h900, 13'd3, 16, 15, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/integration_mem_copy_master.md
Name: integration_mem_copy_master

Overview:
- Avalon-MM master that copies a block of 32-bit words from one region of the on-chip memory to another, one word at a time.
- For each word it issues a read, waits out the slave's fixed read latency, then writes the captured word to the destination address.
- It drives the same slave port signals as the on-chip RAM (word address, byteenable, chipselect, write, writedata, readdata), plus a read strobe and a waitrequest input for use behind the interconnect.
- It sits beside the Nios II in the integration system and is started by a one-cycle pulse from a control register block.

Parameters:
- ADDR_W, 13, word-address width; matches the 5120-word RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- LEN_W, 13, width of the word-count input.
- READ_LATENCY, 1, fixed cycles from read acceptance to valid readdata; legal range 1..4.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; latches src_addr, dst_addr and length.
- src_addr, in, ADDR_W, first source word address.
- dst_addr, in, ADDR_W, first destination word address.
- length, in, LEN_W, number of words to copy.
- busy, out, 1, high while a copy is in progress.
- done, out, 1, one-cycle pulse when a copy completes.
- avm_address, out, ADDR_W, word address.
- avm_byteenable, out, DATA_W/8, all ones whenever read or write is asserted; otherwise zero.
- avm_chipselect, out, 1, high with read or write.
- avm_read, out, 1, read request.
- avm_write, out, 1, write request.
- avm_writedata, out, DATA_W, write data.
- avm_readdata, in, DATA_W, read data from the slave.
- avm_waitrequest, in, 1, slave stall; a request is accepted on a rising edge where waitrequest is low.

Behaviour:
- Reset values: busy=0, done=0, avm_read=0, avm_write=0, avm_chipselect=0, avm_byteenable=0, avm_address=0, avm_writedata=0; FSM in IDLE.
- All outputs are registered.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, FIN.
- IDLE:
  - On start=1: latch src/dst into the running pointers and length into the remaining counter.
  - length=0 -> FIN; otherwise -> RD_REQ.
  - busy rises the cycle after start is sampled.
- RD_REQ:
  - Drive read=1, chipselect=1, address=src pointer.
  - Hold all request signals stable while waitrequest=1.
  - On acceptance: load the latency counter with READ_LATENCY, go to RD_WAIT, deassert read.
- RD_WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, register avm_readdata into avm_writedata and go to WR_REQ.
  - With READ_LATENCY=1 the data captured is the data present in the cycle immediately after acceptance.
- WR_REQ:
  - Drive write=1, chipselect=1, address=dst pointer, writedata=captured word.
  - Hold all request signals stable while waitrequest=1.
  - On acceptance: increment both pointers and decrement the remaining counter.
  - If remaining was 1 -> FIN; otherwise -> RD_REQ.
- FIN: done=1 for exactly one cycle, busy=0 in the same cycle, then -> IDLE.
- Throughput: with waitrequest=0 and READ_LATENCY=1, each word takes 3 cycles.
  - An N-word copy asserts busy for 3N cycles.
  - done is asserted in cycle 3N+1 after start is sampled.
- Pointer overflow: pointers wrap modulo 2^ADDR_W, with no error flag.
- Overlapping regions: strictly ascending read-then-write per word.
  - With dst = src+k, 0 < k < length, the copy propagates data forward; this is the defined, documented behaviour.
- start while busy or in FIN: ignored; latched values are unchanged.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately.
  - The transfer is abandoned; no done pulse is issued.
  - Memory contents already written stay as written.
- length=0: no bus activity; done pulses 1 cycle after start is sampled; busy stays 0.
- At most one bus request is outstanding at any time; read and write are never asserted together.

Test Plan:
- Memory model with READ_LATENCY=1, waitrequest=0; src=0x010, dst=0x100, length=4, src words 0xA0..0xA3 -> writes to 0x100..0x103 with matching data; done pulses in cycle 13; busy is high for exactly 12 cycles.
- Same copy with waitrequest held high for 2 cycles on every request -> address, data and strobes stay stable during each stall; final memory contents are identical; done is delayed by 16 cycles.
- length=0, start pulsed -> no read or write strobe; done=1 one cycle after start; busy never rises.
- src=0x1FFE, dst=0x0000, length=4 -> reads 0x1FFE, 0x1FFF, 0x0000, 0x0001; writes go to 0x0000..0x0003; the overlapping-region propagation at 0x0000/0x0001 matches the reference model.
- start pulsed again mid-copy with different src/dst/length -> ignored; the original copy completes unchanged.
- reset_n pulled low during the WR_REQ of word 2 of 4 -> outputs are zero in the same cycle; words 0..1 are written, word 2 may or may not be written, words 3+ are not; no done pulse; a new start afterwards runs correctly. Repeat with READ_LATENCY=3 -> data is captured 3 cycles after read acceptance.
